mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single unified memory read port between the I-cache and D-cache fill FSMs. Each fill FSM raises a request and presents its block address; the arbiter grants one requester at a time, drives the memory address and read enable from the granted requester, routes returning `mem_data_valid` beats back to it, and holds the grant until a full cache block has returned. Ties are broken round-robin so neither cache can starve the other.

## Interface
- `WORDS_PER_BLOCK`, default 8: data beats per block fill. Must be a power of two, 2..16.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-cache fill FSM requests memory. Held high until its last beat returns.
- `i_addr` in 16: I-cache fill FSM memory address. May change every cycle while granted.
- `d_req` in 1: D-cache fill FSM requests memory.
- `d_addr` in 16: D-cache fill FSM memory address.
- `mem_data_valid` in 1: memory returns a valid data word this cycle.
- `mem_addr` out 16: address to memory. Equals the granted requester's address, else 16'h0000.
- `mem_enable` out 1: memory read enable. High in any GRANT state.
- `i_grant` out 1: I-cache owns memory.
- `d_grant` out 1: D-cache owns memory.
- `i_data_valid` out 1: `mem_data_valid` routed to the I-cache. Equals `mem_data_valid & i_grant`.
- `d_data_valid` out 1: `mem_data_valid & d_grant`.
- `busy` out 1: arbiter is in a GRANT state.

## Operation
- States: IDLE, GRANT_I, GRANT_D. State bits, the `last` bit (last-served requester), and the beat counter (log2(WORDS_PER_BLOCK) bits) are registers.
- Grants are decoded from registered state. `mem_addr` and the routed valids are combinational from grant and inputs.
- IDLE arbitration:
  - Only `d_req` high: go to GRANT_D.
  - Only `i_req` high: go to GRANT_I.
  - Both high: grant the requester not equal to `last`.
  - Neither high: stay in IDLE.
- In GRANT_x:
  - Each `mem_data_valid` increments the counter, modulo WORDS_PER_BLOCK.
  - `x_req` is ignored until the block completes. Deasserting it early does not release the grant, and every beat is still routed to x.
- Final beat is `mem_data_valid` while counter == WORDS_PER_BLOCK-1. On the final beat:
  - Counter wraps to 0 and `last` is set to x.
  - If the other requester's req is high, go directly to its GRANT state (back-to-back handoff, no IDLE cycle).
  - Otherwise go to IDLE.
- The finishing requester is never re-granted directly. It must pass through IDLE, and by then its req has dropped.
- Reset (asserted at any time, including mid-transfer):
  - Immediately: state IDLE, counter 0, `last` = I, so D wins the first tie.
  - All outputs 0, including `mem_addr` = 16'h0000.
  - Beats in flight after reset are ignored: valids are masked because there is no grant.
- `mem_data_valid` in IDLE is dropped. Both routed valids are 0 and the counter holds.

## Timing
- Request to grant: `x_req` sampled high in IDLE at edge N gives `x_grant`, `mem_enable`, `busy` and `mem_addr` = `x_addr` during cycle N+1.
- Release: final beat in cycle M. Grant deasserts in cycle M+1, or the other grant asserts in M+1 on handoff.
- Routed data valid has zero latency: same cycle as `mem_data_valid`.
- `i_grant` and `d_grant` are never high together. `busy` == `i_grant | d_grant`.
- No beat-count timeout. Memory latency between beats is unconstrained.

## Test plan
- Reset: hold `rst_n`=0, drive `mem_data_valid`=1 → all outputs 0, `mem_addr`=0. Release with no req → stays IDLE.
- Single I fill: `i_req`=1 with `i_addr`=16'h1230 at edge 0 → `i_grant`=1 from cycle 1 and `mem_addr`=16'h1230. Send 8 valids → 8 `i_data_valid` pulses. Grant drops the cycle after the 8th; `d_data_valid` stays 0 throughout.
- Tie at reset: `i_req`=`d_req`=1 simultaneously → `d_grant` first. After 8 beats → `i_grant` the next cycle with no IDLE gap. `last`=I afterwards, so the next tie goes to D again.
- Back-to-back: D granted, `i_req` rises mid-transfer → I granted the cycle after D's 8th beat. Beats with gaps of 0–5 idle cycles still count exactly 8.
- Early req drop: D granted, `d_req` deasserts after 3 beats → grant held, 5 more beats routed to D, then IDLE.
- Reset mid-transfer: `rst_n` low after 4 beats of I → grants 0 immediately. After release, `i_req`=1 → fresh grant and counter restarts at 0, so 8 more beats are required.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified memory read port between the I-cache and
// D-cache fill FSMs. One requester owns the port for a whole block fill.
// Simultaneous requests from IDLE alternate round-robin through the last-served
// bit. A block that finishes while the other cache is waiting hands off directly.
module mem_arbiter #(
   parameter int WORDS_PER_BLOCK = 8   // power of two, 2..16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic [15:0] d_addr,
   input  logic        mem_data_valid,
   output logic [15:0] mem_addr,
   output logic        mem_enable,
   output logic        i_grant,
   output logic        d_grant,
   output logic        i_data_valid,
   output logic        d_data_valid,
   output logic        busy
);

   localparam int CW = $clog2(WORDS_PER_BLOCK);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   // Encoding of the last-served bit
   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   state_t        state_reg;
   logic          last_reg;
   logic [CW-1:0] cnt_reg;
   logic          final_beat;

   // A beat that arrives while the counter sits at its top value closes the block
   assign final_beat = mem_data_valid && (cnt_reg == CW'(WORDS_PER_BLOCK - 1));

   // Arbitration FSM, beat counter and last-served bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         last_reg  <= LAST_I;   // D wins the first tie after reset
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Beats arriving in IDLE are dropped and the counter holds
               if (i_req && d_req) begin
                  state_reg <= (last_reg == LAST_I) ? GRANT_D : GRANT_I;
               end else if (d_req) begin
                  state_reg <= GRANT_D;
               end else if (i_req) begin
                  state_reg <= GRANT_I;
               end
            end
            GRANT_I: begin
               // i_req is ignored here; only the block count releases the grant
               if (mem_data_valid) begin
                  cnt_reg <= cnt_reg + CW'(1);   // wraps to 0 on the final beat
                  if (final_beat) begin
                     last_reg  <= LAST_I;
                     state_reg <= d_req ? GRANT_D : IDLE;
                  end
               end
            end
            GRANT_D: begin
               if (mem_data_valid) begin
                  cnt_reg <= cnt_reg + CW'(1);
                  if (final_beat) begin
                     last_reg  <= LAST_D;
                     state_reg <= i_req ? GRANT_I : IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Grants decode straight from the registered state
   assign i_grant    = (state_reg == GRANT_I);
   assign d_grant    = (state_reg == GRANT_D);
   assign busy       = i_grant | d_grant;
   assign mem_enable = busy;

   // Zero-latency routing of returning beats to the current owner
   assign i_data_valid = mem_data_valid & i_grant;
   assign d_data_valid = mem_data_valid & d_grant;

   // Memory address follows the owner and is zero when nobody owns the port
   always_comb begin
      mem_addr = 16'h0000;
      if (i_grant) begin
         mem_addr = i_addr;
      end else if (d_grant) begin
         mem_addr = d_addr;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs are driven on the falling edge.
// Outputs are sampled 1 ns later, so each check covers one cycle.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic [15:0] d_addr;
   logic        mem_data_valid;
   logic [15:0] mem_addr;
   logic        mem_enable;
   logic        i_grant;
   logic        d_grant;
   logic        i_data_valid;
   logic        d_data_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.WORDS_PER_BLOCK(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .d_req          (d_req),
      .d_addr         (d_addr),
      .mem_data_valid (mem_data_valid),
      .mem_addr       (mem_addr),
      .mem_enable     (mem_enable),
      .i_grant        (i_grant),
      .d_grant        (d_grant),
      .i_data_valid   (i_data_valid),
      .d_data_valid   (d_data_valid),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Compare every output against hand-computed values for the current cycle
   task automatic check_outputs(input string tag, input logic ig, input logic dg,
                                input logic [15:0] addr, input logic iv, input logic dv);
      chk({tag, ".i_grant"},      16'(i_grant),      16'(ig));
      chk({tag, ".d_grant"},      16'(d_grant),      16'(dg));
      chk({tag, ".mem_addr"},     mem_addr,          addr);
      chk({tag, ".i_data_valid"}, 16'(i_data_valid), 16'(iv));
      chk({tag, ".d_data_valid"}, 16'(d_data_valid), 16'(dv));
      chk({tag, ".busy"},         16'(busy),         16'(ig | dg));
      chk({tag, ".mem_enable"},   16'(mem_enable),   16'(ig | dg));
   endtask

   task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                        input logic [15:0] da, input logic v);
      @(negedge clk);
      i_req = ir; i_addr = ia; d_req = dr; d_addr = da; mem_data_valid = v;
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_addr = 16'h0; mem_data_valid = 1'b0;
      #1;
      check_outputs("rst_release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // Assert reset between edges, keeping the current requests and a beat in flight
   task automatic assert_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      mem_data_valid = 1'b1;
      #1;
      check_outputs(tag, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_addr = 16'h0; mem_data_valid = 1'b1;

      // Reset holds everything at zero even with requests and beats present
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      check_outputs("rst_hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      drive(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
      check_outputs("rst_req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      release_reset();
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check_outputs("idle_noreq", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn reset: outputs held at zero, idle after release");

      // Single I fill
      drive(1'b1, 16'h1230, 1'b0, 16'h0000, 1'b0);
      check_outputs("i_fill.req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 16'h1230 + 16'(k), 1'b0, 16'h0000, 1'b1);
         check_outputs($sformatf("i_fill.beat%0d", k), 1'b1, 1'b0, 16'h1230 + 16'(k), 1'b1, 1'b0);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);   // beat in IDLE is dropped
      check_outputs("i_fill.release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn single I fill: 8 beats at 1230..1237");

      // Tie right after reset goes to D, then hands off to I with no gap
      assert_reset("tie.rst");
      release_reset();
      drive(1'b1, 16'h4000, 1'b1, 16'h8000, 1'b0);
      check_outputs("tie.req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 16'h4000, 1'b1, 16'h8000, 1'b1);
         check_outputs($sformatf("tie.d_beat%0d", k), 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
      end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 16'h4000, 1'b0, 16'h8000, 1'b1);
         check_outputs($sformatf("tie.i_beat%0d", k), 1'b1, 1'b0, 16'h4000, 1'b1, 1'b0);
      end
      drive(1'b1, 16'h4000, 1'b1, 16'h8000, 1'b0);
      check_outputs("tie2.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 16'h4000, 1'b1, 16'h8000, 1'b0);
      check_outputs("tie2.d_wins", 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 16'h4000, 1'b1, 16'h8000, 1'b1);
         check_outputs($sformatf("tie2.d_beat%0d", k), 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check_outputs("tie2.release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn tie: D then I back-to-back, second tie to D");

      // Back-to-back handoff with irregular beat spacing
      drive(1'b0, 16'h7000, 1'b1, 16'h5000, 1'b0);
      check_outputs("b2b.req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         for (int g = 0; g < k % 6; g++) begin
            drive(k >= 3, 16'h7000, 1'b1, 16'h5000, 1'b0);
            check_outputs($sformatf("b2b.gap%0d_%0d", k, g), 1'b0, 1'b1, 16'h5000, 1'b0, 1'b0);
         end
         drive(k >= 3, 16'h7000, 1'b1, 16'h5000, 1'b1);
         check_outputs($sformatf("b2b.d_beat%0d", k), 1'b0, 1'b1, 16'h5000, 1'b0, 1'b1);
      end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 16'h7000, 1'b0, 16'h0000, 1'b1);
         check_outputs($sformatf("b2b.i_beat%0d", k), 1'b1, 1'b0, 16'h7000, 1'b1, 1'b0);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check_outputs("b2b.release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn back-to-back: D with gaps 0..5, then I");

      // D drops its request after 3 beats; grant is held for the full block
      drive(1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
      check_outputs("drop.req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b1);
         check_outputs($sformatf("drop.beat%0d", k), 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0);
      check_outputs("drop.gap", 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
      for (int k = 3; k < 8; k++) begin
         drive(1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b1);
         check_outputs($sformatf("drop.beat%0d", k), 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check_outputs("drop.release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn early drop: D held for 8 beats");

      // Reset in the middle of an I fill restarts the beat count
      drive(1'b1, 16'h0AA0, 1'b0, 16'h0000, 1'b0);
      check_outputs("mid.req", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'h0AA0, 1'b0, 16'h0000, 1'b1);
         check_outputs($sformatf("mid.beat%0d", k), 1'b1, 1'b0, 16'h0AA0, 1'b1, 1'b0);
      end
      assert_reset("mid.rst");
      release_reset();
      drive(1'b1, 16'h0AA0, 1'b0, 16'h0000, 1'b0);
      check_outputs("mid.rereq", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 16'h0AA0, 1'b0, 16'h0000, 1'b1);
         check_outputs($sformatf("mid.rebeat%0d", k), 1'b1, 1'b0, 16'h0AA0, 1'b1, 1'b0);
      end
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      check_outputs("mid.release", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      $display("txn reset mid-transfer: fresh 8-beat fill after release");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
